// File: rtl/ifetch_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, redirect
// from execute, and the valid/ready handshake toward decode.
//   master : the fetch queue (drives imem_req/imem_addr and dec_* outputs)
//   slave  : memory, execute and decode as seen from the environment
interface ifetch_if #(
  parameter int unsigned ADDR_W = 16
) ();
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              dec_valid;
  logic              dec_ready;
  logic [31:0]       dec_instr;
  logic [5:0]        dec_opcode;
  logic [ADDR_W-1:0] dec_pc;

  modport master (
    output imem_req, imem_addr, dec_valid, dec_instr, dec_opcode, dec_pc,
    input  imem_rdata, redirect_valid, redirect_pc, dec_ready
  );

  modport slave (
    input  imem_req, imem_addr, dec_valid, dec_instr, dec_opcode, dec_pc,
    output imem_rdata, redirect_valid, redirect_pc, dec_ready
  );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction fetch stage: generates the PC, issues word reads to the
// synchronous instruction memory, buffers returned words with their PCs in a
// prefetch FIFO and presents them to decode. A redirect flushes everything.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - ifetch_if.master: imem_req/imem_addr/imem_rdata,
//          redirect_valid/redirect_pc, dec_valid/dec_ready/dec_instr/
//          dec_opcode/dec_pc
// DEPTH must be a power of two (pointers wrap by natural overflow).
module ifetch_queue #(
  parameter int unsigned       ADDR_W   = 16,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic      clk,
  input logic      rst,
  ifetch_if.master bus
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SUM_W = CNT_W + 1;

  logic              rst_q;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic              inflight_q, inflight_d;
  logic              kill_q, kill_d;

  logic [31:0]       instr_mem_q [DEPTH];
  logic [ADDR_W-1:0] pc_mem_q    [DEPTH];

  logic issue_c, push_c, pop_c, dec_valid_c;

  // Issue/push/pop qualifiers. The credit check counts the in-flight slot and
  // deliberately ignores a same-cycle pop, so a returning word always fits.
  always_comb begin
    dec_valid_c = (count_q != '0);
    issue_c     = !rst_q && !bus.redirect_valid &&
                  ((SUM_W'(count_q) + SUM_W'(inflight_q)) < SUM_W'(DEPTH));
    // A word arriving in a redirect cycle belongs to the old path.
    push_c      = inflight_q && !kill_q && !bus.redirect_valid;
    pop_c       = dec_valid_c && bus.dec_ready && !bus.redirect_valid;
  end

  assign bus.imem_req   = issue_c;
  assign bus.imem_addr  = pc_q;
  assign bus.dec_valid  = dec_valid_c;
  assign bus.dec_instr  = instr_mem_q[rd_ptr_q];
  assign bus.dec_opcode = instr_mem_q[rd_ptr_q][31:26];
  assign bus.dec_pc     = pc_mem_q[rd_ptr_q];

  // Next-state for PC, request tracking and FIFO bookkeeping.
  always_comb begin
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    inflight_d = issue_c;
    kill_d     = 1'b0;
    if (bus.redirect_valid) begin
      pc_d     = bus.redirect_pc;
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      kill_d   = inflight_q;
    end else begin
      if (issue_c) begin
        pc_d     = pc_q + ADDR_W'(1);
        req_pc_d = pc_q;
      end
      if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
    end
  end

  // Control state; rst_q marks the idle first cycle after reset release.
  always_ff @(posedge clk) begin
    if (rst) begin
      rst_q      <= 1'b1;
      pc_q       <= RESET_PC;
      req_pc_q   <= '0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      inflight_q <= 1'b0;
      kill_q     <= 1'b0;
    end else begin
      rst_q      <= 1'b0;
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      inflight_q <= inflight_d;
      kill_q     <= kill_d;
    end
  end

  // FIFO payload storage; no reset needed, contents qualified by count.
  always_ff @(posedge clk) begin
    if (!rst && push_c) begin
      instr_mem_q[wr_ptr_q] <= bus.imem_rdata;
      pc_mem_q[wr_ptr_q]    <= req_pc_q;
    end
  end

endmodule
